// File: rtl/aes_pkg.sv
// Shared AES-128 types, FSM encoding, Rcon table and GF(2^8) arithmetic
// for the iterative decryptor.
package aes_pkg;

    localparam int N_DEF  = 128;
    localparam int NR_DEF = 10;
    localparam int NK_DEF = 4;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEXP  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        return gf_mul(x127, x127);
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t r;
        word_t  col;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[127-32*c -: 32];
            r[127-32*c -: 32] = {
                gf_mul(col[31:24], 8'h0e) ^ gf_mul(col[23:16], 8'h0b) ^ gf_mul(col[15:8], 8'h0d) ^ gf_mul(col[7:0], 8'h09),
                gf_mul(col[31:24], 8'h09) ^ gf_mul(col[23:16], 8'h0e) ^ gf_mul(col[15:8], 8'h0b) ^ gf_mul(col[7:0], 8'h0d),
                gf_mul(col[31:24], 8'h0d) ^ gf_mul(col[23:16], 8'h09) ^ gf_mul(col[15:8], 8'h0e) ^ gf_mul(col[7:0], 8'h0b),
                gf_mul(col[31:24], 8'h0b) ^ gf_mul(col[23:16], 8'h0d) ^ gf_mul(col[15:8], 8'h09) ^ gf_mul(col[7:0], 8'h0e)
            };
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES S-box built from GF inverse plus affine map; the default
// is the inverse S-box, INVERSE=0 gives the forward S-box for key expansion.
module aes_inv_sbox
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b1
) (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] fwd_affine(input logic [7:0] a);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8];
        end
        return b ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8];
        end
        return b ^ 8'h05;
    endfunction

    if (INVERSE) begin : g_inv
        assign dout = gf_inv(inv_affine(din));
    end else begin : g_fwd
        assign dout = fwd_affine(gf_inv(din));
    end

endmodule

// File: rtl/decrypt_iterative.sv
// Iterative AES-128 decryptor: on-the-fly key expansion then one inverse round
// per cycle. Define DECRYPT_KEY_CACHE_EN to skip expansion on a repeated key.
module decrypt_iterative
    import aes_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int Nr = NR_DEF,
    parameter int Nk = NK_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in,
    input  logic [N-1:0]   key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out
);

    if (N != 128 || Nr != 10 || Nk != 4) begin : g_bad_params
        $error("decrypt_iterative: only N=128, Nr=10, Nk=4 is supported");
    end

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    block_t      s_q, s_d;
    block_t      out_q, out_d;
    logic        out_valid_q, out_valid_d;

    // Round keys are fully rewritten by every expansion, so no reset is needed.
    block_t      rk_q [0:10];
    block_t      rk_d;
    logic        rk_wr_en;
    logic [3:0]  rk_wr_idx;

    logic        cache_hit;
`ifdef DECRYPT_KEY_CACHE_EN
    logic [N-1:0] cache_key_q, cache_key_d;
    logic         cache_vld_q, cache_vld_d;
    assign cache_hit = cache_vld_q && (key == cache_key_q);
`else
    assign cache_hit = 1'b0;
`endif

    // Key expansion datapath: next round key from rk[cnt].
    block_t prev_rk, kexp_next;
    word_t  rot_word, sub_word, temp_word;
    word_t  n0, n1, n2, n3;

    assign prev_rk  = rk_q[cnt_q];
    assign rot_word = {prev_rk[23:0], prev_rk[31:24]};

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_fwd_sbox
        aes_inv_sbox #(.INVERSE(1'b0)) u_fwd_sbox (
            .din  (rot_word[31-8*gi -: 8]),
            .dout (sub_word[31-8*gi -: 8])
        );
    end

    assign temp_word = sub_word ^ {aes_rcon(cnt_q), 24'h000000};
    assign n0        = prev_rk[127:96] ^ temp_word;
    assign n1        = prev_rk[95:64]  ^ n0;
    assign n2        = prev_rk[63:32]  ^ n1;
    assign n3        = prev_rk[31:0]   ^ n2;
    assign kexp_next = {n0, n1, n2, n3};

    // Inverse round datapath; InvShiftRows is pure wiring into the S-boxes.
    block_t sub_blk, round_rk, added, mixed;

    for (gi = 0; gi < 16; gi++) begin : g_inv_sbox
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
        aes_inv_sbox #(.INVERSE(1'b1)) u_inv_sbox (
            .din  (s_q[127-8*SRC -: 8]),
            .dout (sub_blk[127-8*gi -: 8])
        );
    end

    assign round_rk = rk_q[4'd9 - cnt_q];
    assign added    = sub_blk ^ round_rk;
    assign mixed    = inv_mix_columns(added);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        rk_wr_en    = 1'b0;
        rk_wr_idx   = 4'd0;
        rk_d        = kexp_next;
`ifdef DECRYPT_KEY_CACHE_EN
        cache_key_d = cache_key_q;
        cache_vld_d = cache_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d = 4'd0;
                    if (cache_hit) begin
                        s_d     = in ^ rk_q[10];
                        state_d = ROUND;
                    end else begin
                        s_d       = in;
                        rk_wr_en  = 1'b1;
                        rk_wr_idx = 4'd0;
                        rk_d      = key;
                        state_d   = KEXP;
`ifdef DECRYPT_KEY_CACHE_EN
                        cache_key_d = key;
                        cache_vld_d = 1'b0;
`endif
                    end
                end
            end
            KEXP: begin
                if (cnt_q > 4'd9) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    rk_wr_en  = 1'b1;
                    rk_wr_idx = cnt_q + 4'd1;
                    cnt_d     = cnt_q + 4'd1;
                    if (cnt_q == 4'd9) begin
                        s_d     = s_q ^ kexp_next;
                        state_d = ROUND;
                        cnt_d   = 4'd0;
`ifdef DECRYPT_KEY_CACHE_EN
                        cache_vld_d = 1'b1;
`endif
                    end
                end
            end
            ROUND: begin
                if (cnt_q > 4'd9) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd9) begin
                    s_d         = added;
                    out_d       = added;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                    cnt_d       = 4'd0;
                end else begin
                    s_d   = mixed;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            s_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef DECRYPT_KEY_CACHE_EN
            cache_key_q <= '0;
            cache_vld_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef DECRYPT_KEY_CACHE_EN
            cache_key_q <= cache_key_d;
            cache_vld_q <= cache_vld_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rk_wr_en) begin
            rk_q[rk_wr_idx] <= rk_d;
        end
    end

endmodule
